// File: rtl/rx_frame_store.sv
// rx_frame_store: packs an RMII dibit stream into WORD_W-bit words and holds
// each frame in a circular buffer until its checksum verdict arrives. A frame
// becomes visible to the first-word-fall-through read side only once it is
// committed on done. On kill, or when the buffer runs out of room, the frame
// is rolled back and counted as dropped.
//
// Ports:
//   clk, rstn           clock, asynchronous active-low reset
//   axiiv, axiid[1:0]   input dibit valid / dibit (MSB-first order)
//   done, kill          end-of-frame pulses: checksum good / bad
//   axior               downstream ready
//   axiov, axiod, axiol output word valid / data / last word of frame
//   frame_count         committed frames (wraps)
//   drop_count          discarded frames (wraps)
//   overflow            sticky: a frame was lost to a full buffer
module rx_frame_store #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 512
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              axiiv,
  input  logic [1:0]        axiid,
  input  logic              done,
  input  logic              kill,
  input  logic              axior,
  output logic              axiov,
  output logic [WORD_W-1:0] axiod,
  output logic              axiol,
  output logic [15:0]       frame_count,
  output logic [15:0]       drop_count,
  output logic              overflow
);

  localparam int AW   = $clog2(DEPTH);
  localparam int PW   = AW + 1;
  localparam int HALF = WORD_W / 2;
  localparam int CW   = $clog2(HALF) + 1;
  localparam logic [CW-1:0] HALF_C  = CW'(HALF);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_last;
  logic [PW-1:0]     r_wr_ptr, r_cm_ptr, r_rd_ptr;
  logic [WORD_W-1:0] r_sh;
  logic [CW-1:0]     r_cnt;
  logic              r_active;   // at least one dibit seen since last frame end
  logic              r_bad;      // frame hit a full buffer
  logic [15:0]       r_frame_cnt, r_drop_cnt;
  logic              r_ovf;

  logic              w_dibit, w_end, w_done_only, w_active;
  logic [CW-1:0]     w_cnt_acc;
  logic              w_word_full, w_pad_wr, w_wr_req, w_full, w_wr_en;
  logic              w_bad_next, w_commit, w_drop, w_rd;
  logic [WORD_W-1:0] w_sh_next, w_pad_word, w_wr_data;
  logic [CW:0]       w_shamt;
  logic [PW-1:0]     w_wr_ptr_inc;
  logic [AW-1:0]     w_wr_prev;

  // Dibits of a frame already marked bad are discarded, but still keep the
  // frame "active" so its end is counted as a drop.
  assign w_dibit     = axiiv && !r_bad;
  assign w_end       = done || kill;
  assign w_done_only = done && !kill;
  assign w_active    = r_active || axiiv;

  assign w_cnt_acc   = r_cnt + {{(CW-1){1'b0}}, w_dibit};
  assign w_word_full = w_dibit && (r_cnt == HALF_M1);
  assign w_sh_next   = w_dibit ? {r_sh[WORD_W-3:0], axiid} : r_sh;

  // Left-justify a partial word: the newest 2*cnt bits sit at the bottom of
  // the shifter, older leftovers are pushed out of the top.
  assign w_shamt     = {HALF_C - w_cnt_acc, 1'b0};
  assign w_pad_word  = w_sh_next << w_shamt;
  assign w_pad_wr    = w_done_only && !w_word_full && (w_cnt_acc != '0);
  assign w_wr_data   = w_word_full ? w_sh_next : w_pad_word;

  // Full is judged against the pre-read rd_ptr.
  assign w_full      = (r_wr_ptr - r_rd_ptr) == DEPTH_C;
  assign w_wr_req    = (w_word_full || w_pad_wr) && !r_bad;
  assign w_wr_en     = w_wr_req && !w_full;
  assign w_bad_next  = r_bad || (w_wr_req && w_full);

  assign w_commit    = w_done_only && w_active && !w_bad_next;
  assign w_drop      = w_end && w_active && !w_commit;

  assign w_wr_ptr_inc = r_wr_ptr + {{(PW-1){1'b0}}, w_wr_en};
  assign w_wr_prev    = r_wr_ptr[AW-1:0] - AW'(1);

  assign axiov = (r_rd_ptr != r_cm_ptr);
  assign axiod = axiov ? r_mem[r_rd_ptr[AW-1:0]] : '0;
  assign axiol = axiov && r_last[r_rd_ptr[AW-1:0]];
  assign w_rd  = axiov && axior;

  assign frame_count = r_frame_cnt;
  assign drop_count  = r_drop_cnt;
  assign overflow    = r_ovf;

  // Storage array carries no reset; validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= w_wr_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr    <= '0;
      r_cm_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_last      <= '0;
      r_sh        <= '0;
      r_cnt       <= '0;
      r_active    <= 1'b0;
      r_bad       <= 1'b0;
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_sh <= w_sh_next;

      // A written word carries its own last flag; a frame that ends exactly
      // on a word boundary with no write this cycle flags the previous entry.
      if (w_wr_en)
        r_last[r_wr_ptr[AW-1:0]] <= w_done_only;
      else if (w_commit)
        r_last[w_wr_prev] <= 1'b1;

      if (w_drop) begin
        r_wr_ptr   <= r_cm_ptr;
        r_drop_cnt <= r_drop_cnt + 16'd1;
        if (w_bad_next) r_ovf <= 1'b1;
      end else if (w_commit) begin
        r_wr_ptr    <= w_wr_ptr_inc;
        r_cm_ptr    <= w_wr_ptr_inc;
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end else begin
        r_wr_ptr <= w_wr_ptr_inc;
      end

      if (w_end) begin
        r_cnt    <= '0;
        r_active <= 1'b0;
        r_bad    <= 1'b0;
      end else begin
        if (w_dibit) r_cnt <= w_word_full ? '0 : w_cnt_acc;
        if (axiiv)   r_active <= 1'b1;
        r_bad <= w_bad_next;
      end

      if (w_rd) r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

endmodule
